// File: rtl/multi_blinker.sv
// Multi-channel programmable LED waveform generator: a shared 1 ms prescaler
// drives per-channel phase/burst counters configured at runtime.
module multi_blinker #(
  parameter int unsigned C_CLK_FRQ  = 100_000_000,
  parameter int unsigned C_CHANNELS = 4,
  parameter int unsigned C_MS_WIDTH = 12,
  parameter int unsigned C_BURST    = 3,
  localparam int unsigned CHW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [C_MS_WIDTH-1:0] cfg_period,
  input  logic [C_MS_WIDTH-1:0] cfg_high,
  input  logic                  sync,
  output logic                  tick,
  output logic [C_CHANNELS-1:0] out
);

  localparam int unsigned PRE_N = C_CLK_FRQ / 1000;
  localparam int unsigned PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam int unsigned BW    = $clog2(2 * C_BURST);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRE_N - 1);
  localparam logic [BW-1:0]    BURST_LAST = BW'(2 * C_BURST - 1);
  localparam logic [BW-1:0]    BURST_ON   = BW'(C_BURST);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_t;

  logic [PRE_W-1:0]      r_presc;
  logic                  r_tick;
  mode_t                 r_mode   [C_CHANNELS];
  logic [C_MS_WIDTH-1:0] r_period [C_CHANNELS];
  logic [C_MS_WIDTH-1:0] r_high   [C_CHANNELS];
  logic [C_MS_WIDTH-1:0] r_phase  [C_CHANNELS];
  logic [BW-1:0]         r_burst  [C_CHANNELS];
  logic [C_CHANNELS-1:0] r_out;
  logic [C_CHANNELS-1:0] w_out;
  logic [C_CHANNELS-1:0] w_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_presc == PRE_LAST);
      r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  // Out-of-range channel numbers match no decode bit and are dropped.
  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < C_CHANNELS; i++)
      w_wr[i] = cfg_we && (cfg_ch == CHW'(i));
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < C_CHANNELS; i++) begin
      if (rst) begin
        r_mode[i]   <= M_OFF;
        r_period[i] <= '0;
        r_high[i]   <= '0;
        r_phase[i]  <= '0;
        r_burst[i]  <= '0;
      end else if (w_wr[i] || sync) begin
        // A clear in the same cycle as a tick swallows that tick.
        if (w_wr[i]) begin
          r_mode[i]   <= mode_t'(cfg_mode);
          r_period[i] <= cfg_period;
          r_high[i]   <= cfg_high;
        end
        r_phase[i] <= '0;
        r_burst[i] <= '0;
      end else if (r_tick && (r_period[i] != '0)) begin
        if (r_phase[i] == r_period[i] - 1'b1) begin
          r_phase[i] <= '0;
          r_burst[i] <= (r_burst[i] == BURST_LAST) ? '0 : r_burst[i] + 1'b1;
        end else begin
          r_phase[i] <= r_phase[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_out = '0;
    for (int unsigned i = 0; i < C_CHANNELS; i++) begin
      case (r_mode[i])
        M_OFF:   w_out[i] = 1'b0;
        M_ON:    w_out[i] = 1'b1;
        M_BLINK: w_out[i] = (r_period[i] != '0) && (r_phase[i] < r_high[i]);
        M_BURST: w_out[i] = (r_period[i] != '0) && (r_phase[i] < r_high[i])
                            && (r_burst[i] < BURST_ON);
        default: w_out[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_out;
  end

  assign out  = r_out;
  assign tick = r_tick;

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker at 4 cycles/ms; expected waveforms are
// hand-derived timelines indexed by the cycle count e after reset release.
module tb_multi_blinker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_we5 = 1'b0;
  logic        sync = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [2:0]  cfg_ch5 = '0;
  logic [1:0]  cfg_mode = '0;
  logic [11:0] cfg_period = '0;
  logic [11:0] cfg_high = '0;
  logic        tick, tick5;
  logic [3:0]  out;
  logic [4:0]  out5;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          e = 0;

  always #5 clk = ~clk;

  multi_blinker #(.C_CLK_FRQ(4000), .C_CHANNELS(4), .C_MS_WIDTH(12), .C_BURST(2)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .sync(sync), .tick(tick), .out(out)
  );

  // Five channels give a 3-bit channel port, so cfg_ch=5 is representable.
  multi_blinker #(.C_CLK_FRQ(4000), .C_CHANNELS(5), .C_MS_WIDTH(12), .C_BURST(2)) u_dut5 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .sync(sync), .tick(tick5), .out(out5)
  );

  function automatic logic [3:0] exp_out(int c);
    logic b0, b1, b2;
    int   m;
    b0 = 1'b0; b1 = 1'b0; b2 = 1'b0;
    if (c >= 7 && c <= 9)          b0 = 1'b1;
    else if (c >= 22 && c <= 173)  b0 = ((c - 22) % 16) < 4;
    else if (c >= 174 && c <= 201) b0 = ((c - 174) % 16) < 4;
    else if (c >= 202 && c <= 265) b0 = ((c - 202) % 16) < 4;
    if ((c >= 39 && c <= 41) || (c >= 46 && c <= 49)) b1 = 1'b1;
    else if (c >= 70 && c <= 201) begin
      m = (c - 70) % 32;
      b1 = (m < 4) || (m >= 8 && m < 12);
    end else if (c >= 202 && c <= 265) begin
      m = (c - 202) % 32;
      b1 = (m < 4) || (m >= 8 && m < 12);
    end
    if ((c >= 127 && c <= 146) || (c >= 162 && c <= 265)) b2 = 1'b1;
    return {1'b0, b2, b1, b0};
  endfunction

  function automatic logic exp_tick(int c);
    if (c <= 0)   return 1'b0;
    if (c < 266)  return (c % 4) == 0;
    if (c <= 267) return 1'b0;
    return ((c - 267) % 4) == 0;
  endfunction

  function automatic logic [4:0] exp5(int c);
    return (c >= 246 && c < 266) ? 5'b10000 : 5'b00000;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s e=%0d observed=%0h expected=%0h", tag, e, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    e++;
    chk("out", {4'b0, out}, {4'b0, exp_out(e)});
    chk("tick", {7'b0, tick}, {7'b0, exp_tick(e)});
    chk("tick5", {7'b0, tick5}, {7'b0, exp_tick(e)});
    chk("out5", {3'b0, out5}, {3'b0, exp5(e)});
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic wr(input int ch, input logic [1:0] m, input int p, input int h);
    cfg_ch = 2'(ch); cfg_mode = m; cfg_period = 12'(p); cfg_high = 12'(h);
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr5(input int ch, input logic [1:0] m);
    cfg_ch5 = 3'(ch); cfg_mode = m; cfg_period = 12'd0; cfg_high = 12'd0;
    cfg_we5 = 1'b1;
    step();
    cfg_we5 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", {4'b0, out}, 8'h00);
    chk("rst_tick", {7'b0, tick}, 8'h00);
    chk("rst_out5", {3'b0, out5}, 8'h00);
    rst = 1'b0;

    run_to(5);   wr(0, 2'd2, 4, 1);   // ch0 BLINK P=4 H=1
    run_to(37);  wr(1, 2'd3, 2, 1);   // ch1 BURST P=2 H=1
    run_to(105); wr(2, 2'd2, 5, 0);   // H=0 -> low
    run_to(125); wr(2, 2'd2, 5, 7);   // H>P -> high
    run_to(145); wr(2, 2'd2, 0, 3);   // P=0 -> low
    run_to(160); wr(2, 2'd1, 0, 0);   // ON
    run_to(172); wr(0, 2'd2, 4, 1);   // rewrite coinciding with a tick
    run_to(200);
    sync = 1'b1; step(); sync = 1'b0; // sync on a tick edge
    run_to(240); wr5(5, 2'd1);        // invalid channel
    run_to(242); wr5(7, 2'd1);        // invalid channel
    run_to(244); wr5(4, 2'd1);        // highest valid channel
    run_to(265);
    rst = 1'b1; step(); step(); rst = 1'b0;
    run_to(290);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_blinker.md
# multi_blinker

Multi-channel, runtime-programmable square-wave generator for LED and indicator outputs. A shared 1 ms prescaler drives C_CHANNELS independent phase counters. Each channel has its own period, high time and mode (off, on, blink, burst), written through a simple configuration port. The block sits between the control fabric and the board LED pins, and provides the periodic indicator waveforms that the design previously produced with fixed-period blinkers.

## Interface

Parameters:
- C_CLK_FRQ, 100_000_000: clock frequency [Hz]. Must be a multiple of 1000.
- C_CHANNELS, 4: number of output channels, 1..16.
- C_MS_WIDTH, 12: width of the period and high-time fields [ms units].
- C_BURST, 3: pulses per burst in BURST mode, ≥1.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous reset, active high.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(C_CHANNELS))  target channel. Values ≥ C_CHANNELS are ignored.
- cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- cfg_period  in  C_MS_WIDTH  period P [ms].
- cfg_high  in  C_MS_WIDTH  high time H [ms].
- sync  in  1  restarts the phase of all channels.
- tick  out  1  1 ms strobe, one cycle wide.
- out  out  C_CHANNELS  channel waveforms, registered.

## Operation

Prescaler:
- Counts 0..C_CLK_FRQ/1000−1, then wraps to 0.
- tick is registered. It is high for exactly the one cycle after the prescaler reaches its terminal count.

Per-channel state:
- mode, P, H.
- phase counter, C_MS_WIDTH bits.
- burst counter, $clog2(2·C_BURST) bits.

Phase counter:
- Advances on each tick cycle.
- When phase = P−1 it wraps to 0. Each wrap is a "period end".
- P=0: phase stays at 0 and the channel output is low in BLINK and BURST.

Waveform level w:
- w = (phase < H).
- H=0 gives constant low; H ≥ P gives constant high.

Burst counter:
- Counts 0..2·C_BURST−1 and increments on each period end.
- Wraps to 0 after 2·C_BURST−1.

Output per mode:
- OFF: out = 0.
- ON: out = 1.
- BLINK: out = w.
- BURST: out = w while burst counter < C_BURST, else 0. The result is C_BURST pulses followed by C_BURST silent periods.

Configuration write (cfg_we=1, valid cfg_ch):
- Loads mode, P and H into the selected channel.
- Clears that channel's phase and burst counter.
- Leaves the other channels untouched.

sync=1:
- Clears the phase and burst counter of every channel.
- Does not clear the prescaler.

Precedence, highest first:
- rst.
- cfg write or sync. Both clear counters, so applying them together is consistent.
- tick advance. A tick in the same cycle as a clear is lost for the affected channels.

## Timing

Reset values (rst high at an edge):
- prescaler 0; tick 0.
- all modes OFF; P=0; H=0; phase 0; burst counter 0.
- out = 0 from the cycle after that edge.
- The first tick appears C_CLK_FRQ/1000 cycles after rst deasserts.

Latency:
- out is registered from channel state, so it lags state by one cycle.
- A config written at edge k shows on out after edge k+1.
- A phase change at a tick edge shows on out one edge later.

Handshake:
- None. cfg_we is accepted every cycle.
- Back-to-back writes to the same channel: the last one wins.

Wrap-around:
- The phase compare uses P−1 on C_MS_WIDTH bits.
- P = 2^C_MS_WIDTH−1 is the maximum period.
- No overflow is possible because phase < P at all times.

Mid-operation:
- Writing P smaller than the current phase is safe, because the write clears phase.
- rst mid-burst returns the channel to OFF.

## Test plan

All tests use C_CLK_FRQ=4000 (4 cycles per ms), C_CHANNELS=4, C_BURST=2.

1. Reset: hold rst 3 cycles, release -> out=0000 and tick=0 at reset. First tick occurs 4 cycles after release, then every 4 cycles.
2. BLINK on channel 0 with P=4, H=1 -> out[0] high 4 cycles, low 12, period 16 cycles. Other channels stay 0.
3. BURST on channel 1 with P=2, H=1 -> two 4-cycle pulses 8 cycles apart, then 16 cycles low, repeating every 32 cycles.
4. Boundaries on channel 2:
   - H=0, P=5 -> constantly 0.
   - H=7, P=5 -> constantly 1.
   - P=0 in BLINK -> 0.
   - mode ON -> 1 one cycle after the write.
5. Collisions:
   - cfg write to channel 0 in the same cycle as tick -> phase 0, so the high pulse restarts.
   - sync with channels 0 and 1 running at different phases -> both realign and their rising edges coincide.
   - cfg_ch=5 -> no channel changes.
6. rst asserted mid-burst -> out=0000 the next cycle. All channels stay OFF after release until rewritten.
